pipelined_barrel_shifter: RTL and testbench

Parametrised, pipelined successor to the combinational shifter. Performs logical-left, logical-right, arithmetic-right and rotate-right on N-bit words. Uses a valid/ready handshake on input and output, with full backpressure. Sits between the operand-issue stage and the writeback mux of the datapath; sustains one operation per cycle at a fixed latency of STAGES cycles.

---
 rtl/pipelined_barrel_shifter_if.sv | 33 +++
 rtl/pipelined_barrel_shifter.sv | 117 +++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_barrel_shifter_if.sv
// Handshake bundle for pipelined_barrel_shifter.
//   in_*  : operation channel (valid/ready), operand, shift amount, op, tag
//   out_* : result channel (valid/ready), result, tag, zero flag
// master = operand-issue side (drives in_*, out_ready); slave = the shifter.
interface pipelined_barrel_shifter_if #(
  parameter int N     = 16,
  parameter int TAG_W = 4
);
  localparam int M = $clog2(N);

  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic [M-1:0]     in_shamt;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_zero;

  modport master (
    output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_zero
  );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined log barrel shifter: SLL / SRL / SRA / ROR on N-bit words.
// Register 0 captures the accepted operation; registers 1..STAGES each apply
// a contiguous group of the M shift-by-2^k levels, so a result accepted on
// edge t is presented after edge t+STAGES. One global advance enable gives
// full backpressure with no bubbles inserted.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of pipelined_barrel_shifter_if (in_* / out_* channels)
module pipelined_barrel_shifter #(
  parameter int N      = 16,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input logic                        clk,
  input logic                        rst_n,
  pipelined_barrel_shifter_if.slave  bus
);
  localparam int M = $clog2(N);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  if (N < 4 || (N & (N - 1)) != 0) begin : g_bad_n
    $error("pipelined_barrel_shifter: N must be a power of two >= 4");
  end
  if (STAGES < 1 || STAGES > M) begin : g_bad_stages
    $error("pipelined_barrel_shifter: STAGES must be in 1..$clog2(N)");
  end

  // Levels owned by compute group s: k in [s*M/STAGES, (s+1)*M/STAGES).
  function automatic logic [M-1:0] lvl_mask(input int s);
    lvl_mask = '0;
    for (int k = 0; k < M; k++)
      lvl_mask[k] = (k >= s * M / STAGES) && (k < (s + 1) * M / STAGES);
  endfunction

  // One log-shifter level. SRA stays exact across levels because every
  // earlier SRA level preserves the original sign bit in the MSB.
  function automatic logic [N-1:0] lvl_shift(input logic [N-1:0] d,
                                             input logic [1:0]   op,
                                             input int           amt);
    logic [2*N-1:0]      dd;
    logic signed [N-1:0] sd;
    dd = {d, d} >> amt;
    sd = d;
    case (op)
      OP_SLL:  lvl_shift = d << amt;
      OP_SRL:  lvl_shift = d >> amt;
      OP_SRA:  lvl_shift = sd >>> amt;
      default: lvl_shift = dd[N-1:0];
    endcase
  endfunction

  // Register s holds the operation after s compute groups have been applied.
  logic [STAGES:0]    r_vld_pipe;
  logic [N-1:0]       r_data [STAGES+1];
  logic [TAG_W-1:0]   r_tag  [STAGES+1];
  logic [1:0]         r_op   [STAGES];
  logic [M-1:0]       r_sh   [STAGES];   // only bits not yet consumed
  logic               r_zero;

  logic               w_adv;
  logic [M-1:0]       w_en  [STAGES];
  logic [N-1:0]       w_nxt [STAGES];

  // Whole pipe moves together; ready depends only on state and out_ready.
  assign w_adv        = !r_vld_pipe[STAGES] || bus.out_ready;
  assign bus.in_ready = w_adv;

  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      w_en[s]  = r_sh[s] & lvl_mask(s);
      w_nxt[s] = r_data[s];
      for (int k = 0; k < M; k++)
        if (w_en[s][k]) w_nxt[s] = lvl_shift(w_nxt[s], r_op[s], 1 << k);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_zero     <= 1'b0;
      for (int s = 0; s <= STAGES; s++) begin
        r_data[s] <= '0;
        r_tag[s]  <= '0;
      end
      for (int s = 0; s < STAGES; s++) begin
        r_op[s] <= '0;
        r_sh[s] <= '0;
      end
    end else if (w_adv) begin
      // Bubbles enter as invalid slots; inputs are only captured here.
      r_vld_pipe <= {r_vld_pipe[STAGES-1:0], bus.in_valid};
      r_data[0]  <= bus.in_data;
      r_tag[0]   <= bus.in_tag;
      r_op[0]    <= bus.in_op;
      r_sh[0]    <= bus.in_shamt;
      for (int s = 1; s <= STAGES; s++) begin
        r_data[s] <= w_nxt[s-1];
        r_tag[s]  <= r_tag[s-1];
      end
      for (int s = 1; s < STAGES; s++) begin
        r_op[s] <= r_op[s-1];
        r_sh[s] <= r_sh[s-1] & ~lvl_mask(s-1);
      end
      // Zero flag registered alongside the final data, not derived from it.
      r_zero <= ~|w_nxt[STAGES-1];
    end
  end

  assign bus.out_valid = r_vld_pipe[STAGES];
  assign bus.out_data  = r_data[STAGES];
  assign bus.out_tag   = r_tag[STAGES];
  assign bus.out_zero  = r_zero;
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
`timescale 1ns/1ps
module tb_pipelined_barrel_shifter;
  localparam int N = 16, TAG_W = 4, STAGES = 2, LAT = STAGES, NV = 15;
  localparam logic [1:0] SLL = 2'd0, SRL = 2'd1, SRA = 2'd2, ROR = 2'd3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pipelined_barrel_shifter_if #(.N(N), .TAG_W(TAG_W)) bus ();
  pipelined_barrel_shifter #(.N(N), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct packed { logic [15:0] d; logic [3:0] sh; logic [1:0] op; logic [15:0] exp; } vec_t;
  typedef struct packed { logic [15:0] d; logic [3:0] t; } exp_t;

  vec_t vt [NV];
  exp_t sb [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [15:0] d, input logic [3:0] sh,
                                        input logic [1:0] op);
    logic [31:0]        dd;
    logic signed [15:0] sd;
    dd = {d, d} >> sh;
    sd = d;
    case (op)
      SLL:     model = d << sh;
      SRL:     model = d >> sh;
      SRA:     model = sd >>> sh;
      default: model = dd[15:0];
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic [3:0] sh, input logic [1:0] op,
                      input logic [3:0] t);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_shamt = sh;
    bus.in_op    = op;
    bus.in_tag   = t;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_data  = 16'hDEAD;
    bus.in_shamt = 4'd7;
    bus.in_op    = ROR;
    bus.in_tag   = 4'hF;
  endtask

  // Scoreboard: expected results queued on accept, checked in order on consume;
  // while stalled the presented result must hold.
  initial begin
    logic        was_stall;
    logic [15:0] hold_d;
    logic [3:0]  hold_t;
    exp_t        e;
    was_stall = 1'b0;
    hold_d = '0;
    hold_t = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        was_stall = 1'b0;
      end else begin
        if (was_stall) begin
          chk("hold_data", bus.out_data, hold_d);
          chk("hold_tag", bus.out_tag, hold_t);
        end
        if (bus.out_valid && bus.out_ready) begin
          chk("sb_nonempty", 32'(sb.size() == 0), 0);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("sb_data", bus.out_data, e.d);
            chk("sb_tag", bus.out_tag, e.t);
            chk("sb_zero", bus.out_zero, (e.d == 16'h0));
          end
        end
        if (bus.in_valid && bus.in_ready)
          sb.push_back('{d: model(bus.in_data, bus.in_shamt, bus.in_op), t: bus.in_tag});
        was_stall = bus.out_valid && !bus.out_ready;
        hold_d    = bus.out_data;
        hold_t    = bus.out_tag;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [10:0] pat;
    logic        exp_v;

    vt[0]  = '{16'hA5A5, 4'd15, SLL, 16'h8000};
    vt[1]  = '{16'hA5A5, 4'd15, SRL, 16'h0001};
    vt[2]  = '{16'hF0F0, 4'd15, SRA, 16'hFFFF};
    vt[3]  = '{16'h1A2B, 4'd4,  ROR, 16'hB1A2};
    vt[4]  = '{16'hA5A5, 4'd0,  SLL, 16'hA5A5};
    vt[5]  = '{16'hA5A5, 4'd0,  SRL, 16'hA5A5};
    vt[6]  = '{16'hA5A5, 4'd0,  SRA, 16'hA5A5};
    vt[7]  = '{16'hA5A5, 4'd0,  ROR, 16'hA5A5};
    vt[8]  = '{16'h1A2B, 4'd15, SRA, 16'h0000};
    vt[9]  = '{16'h8000, 4'd15, SRA, 16'hFFFF};
    vt[10] = '{16'h0001, 4'd1,  ROR, 16'h8000};
    vt[11] = '{16'h8421, 4'd7,  SLL, 16'h1080};
    vt[12] = '{16'h8421, 4'd9,  SRL, 16'h0042};
    vt[13] = '{16'h8421, 4'd9,  SRA, 16'hFFC2};
    vt[14] = '{16'h8421, 4'd9,  ROR, 16'h10C2};

    idle();
    bus.out_ready = 1'b1;

    // Reset state
    #3;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_tag", bus.out_tag, 0);
    chk("rst_out_zero", bus.out_zero, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("rdy_after_rst", bus.in_ready, 1);

    // Directed vectors back-to-back: one result per cycle, LAT edges after accept
    for (int i = 0; i < NV + LAT; i++) begin
      if (i < NV) send(vt[i].d, vt[i].sh, vt[i].op, 4'(i + 1));
      else        idle();
      cyc();
      if (i >= LAT) begin
        chk($sformatf("v%0d_valid", i - LAT), bus.out_valid, 1);
        chk($sformatf("v%0d_data", i - LAT), bus.out_data, vt[i - LAT].exp);
        chk($sformatf("v%0d_tag", i - LAT), bus.out_tag, 32'(i - LAT + 1));
        chk($sformatf("v%0d_zero", i - LAT), bus.out_zero, (vt[i - LAT].exp == 16'h0));
      end
    end
    cyc();
    chk("vec_drained", bus.out_valid, 0);

    // Backpressure: fill, stall five cycles with junk on the inputs, release
    bus.out_ready = 1'b0;
    send(16'h8001, 4'd1, ROR, 4'd5); cyc();
    send(16'h0F00, 4'd4, SLL, 4'd6); cyc();
    send(16'h8000, 4'd3, SRA, 4'd7); cyc();
    for (int i = 0; i < 5; i++) begin
      send(16'h1234 + 16'(i), 4'(i), 2'(i), 4'hE);
      chk("stall_ready", bus.in_ready, 0);
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_data", bus.out_data, 16'hC000);
      chk("stall_tag", bus.out_tag, 5);
      cyc();
    end
    send(16'h00F0, 4'd4, SRL, 4'd8);
    bus.out_ready = 1'b1;
    cyc();
    idle();
    chk("drain6_tag", bus.out_tag, 6);
    chk("drain6_data", bus.out_data, 16'hF000);
    cyc();
    chk("drain7_tag", bus.out_tag, 7);
    chk("drain7_data", bus.out_data, 16'hF000);
    cyc();
    chk("drain8_tag", bus.out_tag, 8);
    chk("drain8_data", bus.out_data, 16'h000F);
    chk("drain8_valid", bus.out_valid, 1);
    cyc();
    chk("drain_done", bus.out_valid, 0);

    // Bubbles: gaps of 1..3 cycles reappear LAT edges later
    pat = 11'b11000100101;
    for (int i = 0; i < 11 + LAT + 1; i++) begin
      if (i < 11 && pat[i]) send(16'h0100 + 16'(i), 4'(i), 2'(i), 4'(i));
      else                  idle();
      cyc();
      if (i >= LAT) begin
        exp_v = (i - LAT < 11) ? pat[i - LAT] : 1'b0;
        chk($sformatf("bub%0d_valid", i - LAT), bus.out_valid, exp_v);
      end
    end

    // Reset between edges with operations in flight
    send(16'h0003, 4'd1, SLL, 4'd9);  cyc();
    send(16'h0005, 4'd2, SLL, 4'd10); cyc();
    send(16'h0007, 4'd0, SRL, 4'd11); cyc();
    idle();
    chk("pre_rst_valid", bus.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", bus.out_valid, 0);
    chk("midrst_data", bus.out_data, 0);
    sb.delete();
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("post_rst_quiet", bus.out_valid, 0);
    end
    send(16'h0001, 4'd1, SLL, 4'd14); cyc();
    idle(); cyc();
    chk("post_rst_early", bus.out_valid, 0);
    cyc();
    chk("post_rst_valid", bus.out_valid, 1);
    chk("post_rst_data", bus.out_data, 16'h0002);
    chk("post_rst_tag", bus.out_tag, 14);
    cyc();

    // Random ops and random backpressure, checked by the scoreboard
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0)
        send(16'($urandom), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
             4'($urandom_range(0, 15)));
      else
        idle();
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    idle();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10 && sb.size() != 0; i++) cyc();
    chk("rand_drained", sb.size(), 0);
    cyc();
    chk("rand_idle", bus.out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
